// File: rtl/pixel_stream_tx_pkg.sv
// Shared defaults and FSM state type for the pixel stream frame source.
package pixel_stream_tx_pkg;

    localparam int unsigned IMG_W_DEF  = 320;
    localparam int unsigned IMG_H_DEF  = 240;
    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = $clog2(IMG_W_DEF * IMG_H_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LINE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Control, memory-read and pixel-stream signals of pixel_stream_tx.
interface pixel_stream_tx_if
    import pixel_stream_tx_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              start_in;
    logic              mem_rd_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [PIX_W-1:0]  mem_data_in;
    logic [PIX_W-1:0]  pixel_data_out;
    logic              pixel_data_valid_out;
    logic              line_done_in;
    logic              busy_out;
    logic              frame_done_out;
    logic              credit_err_out;

    modport master (
        input  start_in, mem_data_in, line_done_in,
        output mem_rd_out, mem_addr_out, pixel_data_out, pixel_data_valid_out,
               busy_out, frame_done_out, credit_err_out
    );

    modport slave (
        output start_in, mem_data_in, line_done_in,
        input  mem_rd_out, mem_addr_out, pixel_data_out, pixel_data_valid_out,
               busy_out, frame_done_out, credit_err_out
    );
endinterface

// File: rtl/pixel_stream_tx_rd_latency_pipe.sv
// Valid shift register matching the memory read latency; o_busy flags reads in flight.
module rd_latency_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_rd,
    output logic o_valid,
    output logic o_busy
);
    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | DEPTH'(i_rd);
        end
    end

    assign o_valid = r_pipe[DEPTH-1];
    assign o_busy  = |r_pipe;
endmodule

// File: rtl/pixel_stream_tx.sv
// Raster-order frame reader with line-credit flow control toward the line-buffer front end.
module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int unsigned IMG_W         = IMG_W_DEF,
    parameter int unsigned IMG_H         = IMG_H_DEF,
    parameter int unsigned PIX_W         = PIX_W_DEF,
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned PRELOAD_LINES = 4,
    parameter int unsigned MEM_LAT       = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    pixel_stream_tx_if.master     bus
);
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned LINE_W = $clog2(IMG_H);
    localparam int unsigned CW     = $clog2(PRELOAD_LINES + 1);

    tx_state_t         r_state, w_next_state;
    logic [COL_W-1:0]  r_col;
    logic [LINE_W-1:0] r_line;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_credits, w_credits_nxt;
    logic              r_err;

    logic              w_rd, w_line_end, w_last_line, w_ld_ok, w_err_set;
    logic              w_valid, w_pipe_busy, w_frame_done;
    logic [PIX_W-1:0]  w_pix;

    assign w_rd        = (r_state == LINE);
    assign w_line_end  = w_rd && (r_col == COL_W'(IMG_W - 1));
    assign w_last_line = (r_line == LINE_W'(IMG_H - 1));
    assign w_ld_ok     = bus.line_done_in && ((r_state == LINE) || (r_state == WAIT));
    assign w_err_set   = w_ld_ok && !w_line_end && (r_credits == CW'(PRELOAD_LINES));

    // A line end and a returned credit in the same cycle cancel out.
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_line_end && !w_ld_ok) begin
            w_credits_nxt = r_credits - CW'(1);
        end else if (!w_line_end && w_ld_ok && (r_credits != CW'(PRELOAD_LINES))) begin
            w_credits_nxt = r_credits + CW'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_in) w_next_state = LINE;
            end
            LINE: begin
                if (w_line_end) begin
                    if (w_last_line)               w_next_state = DRAIN;
                    else if (w_credits_nxt == '0)  w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_credits != '0) w_next_state = LINE;
            end
            DRAIN: begin
                if (!w_pipe_busy) begin
                    w_frame_done = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_col     <= '0;
            r_line    <= '0;
            r_addr    <= '0;
            r_credits <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= r_err | w_err_set;
            if ((r_state == IDLE) && bus.start_in) begin
                r_col     <= '0;
                r_line    <= '0;
                r_addr    <= '0;
                r_credits <= CW'(PRELOAD_LINES);
            end else begin
                r_credits <= w_credits_nxt;
                if (w_rd) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_line_end) begin
                        r_col  <= '0;
                        r_line <= r_line + LINE_W'(1);
                    end else begin
                        r_col  <= r_col + COL_W'(1);
                    end
                end
            end
        end
    end

    rd_latency_pipe #(.DEPTH(MEM_LAT)) u_rd_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_rd    (w_rd),
        .o_valid (w_valid),
        .o_busy  (w_pipe_busy)
    );

    // Memory data is passed straight through but held at zero outside valid cycles.
    assign w_pix = w_valid ? bus.mem_data_in : '0;

    assign bus.mem_rd_out           = w_rd;
    assign bus.mem_addr_out         = r_addr;
    assign bus.pixel_data_out       = w_pix;
    assign bus.pixel_data_valid_out = w_valid;
    assign bus.busy_out             = (r_state != IDLE);
    assign bus.frame_done_out       = w_frame_done;
    assign bus.credit_err_out       = r_err;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: MEM_LAT=1 and MEM_LAT=3 instances share one stimulus.
module tb_pixel_stream_tx;
    import pixel_stream_tx_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ld    = 1'b0;
    logic mon_clr = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pixel_stream_tx_if #(.PIX_W(8), .ADDR_W(ADDR_W_DEF)) ifa ();
    pixel_stream_tx_if #(.PIX_W(8), .ADDR_W(ADDR_W_DEF)) ifb ();

    pixel_stream_tx #(.MEM_LAT(1)) dut_a (.clk_in(clk), .rst_in(rst_n), .bus(ifa));
    pixel_stream_tx #(.MEM_LAT(3)) dut_b (.clk_in(clk), .rst_in(rst_n), .bus(ifb));

    // Image memory models: data = addr[7:0], latency 1 and 3.
    logic [7:0] ma = '0;
    logic [7:0] mb0 = '0, mb1 = '0, mb2 = '0;
    always @(posedge clk) begin
        ma  <= ifa.mem_addr_out[7:0];
        mb0 <= ifb.mem_addr_out[7:0];
        mb1 <= mb0;
        mb2 <= mb1;
    end

    assign ifa.start_in = start;
    assign ifb.start_in = start;
    assign ifa.line_done_in = ld;
    assign ifb.line_done_in = ld;
    assign ifa.mem_data_in = ma;
    assign ifb.mem_data_in = mb2;

    logic        rd [2];
    logic        vld[2];
    logic        fd [2];
    logic [16:0] addr[2];
    logic [7:0]  pix[2];
    assign rd[0] = ifa.mem_rd_out;            assign rd[1] = ifb.mem_rd_out;
    assign vld[0] = ifa.pixel_data_valid_out; assign vld[1] = ifb.pixel_data_valid_out;
    assign fd[0] = ifa.frame_done_out;        assign fd[1] = ifb.frame_done_out;
    assign addr[0] = ifa.mem_addr_out;        assign addr[1] = ifb.mem_addr_out;
    assign pix[0] = ifa.pixel_data_out;       assign pix[1] = ifb.pixel_data_out;

    int unsigned rd_cnt[2], addr_err[2], pix_cnt[2], pix_err[2];
    int unsigned fd_cnt[2], fd_align_err[2], bursts[2];
    logic prev_rd[2], prev_vld[2];

    // The n-th read of a frame must address n; the n-th pixel must carry n[7:0].
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_clr) begin
                rd_cnt[i] <= 0; addr_err[i] <= 0; pix_cnt[i] <= 0; pix_err[i] <= 0;
                fd_cnt[i] <= 0; fd_align_err[i] <= 0; bursts[i] <= 0;
                prev_rd[i] <= 1'b0; prev_vld[i] <= 1'b0;
            end else begin
                if (rd[i]) begin
                    if (addr[i] != 17'(rd_cnt[i])) addr_err[i] <= addr_err[i] + 1;
                    if (!prev_rd[i]) bursts[i] <= bursts[i] + 1;
                    rd_cnt[i] <= rd_cnt[i] + 1;
                end
                if (vld[i]) begin
                    if (pix[i] != 8'(pix_cnt[i])) pix_err[i] <= pix_err[i] + 1;
                    pix_cnt[i] <= pix_cnt[i] + 1;
                end
                if (fd[i]) begin
                    fd_cnt[i] <= fd_cnt[i] + 1;
                    if (!prev_vld[i]) fd_align_err[i] <= fd_align_err[i] + 1;
                end
                prev_rd[i]  <= rd[i];
                prev_vld[i] <= vld[i];
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        step(1);
        mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        total++; if ({ifa.mem_rd_out, ifa.mem_addr_out, ifa.pixel_data_valid_out, ifa.pixel_data_out, ifa.busy_out, ifa.frame_done_out, ifa.credit_err_out} !== 31'd0) begin
            bad++; $display("FAIL reset_outs_a got=%h want=0", {ifa.mem_rd_out, ifa.mem_addr_out, ifa.pixel_data_valid_out, ifa.pixel_data_out, ifa.busy_out, ifa.frame_done_out, ifa.credit_err_out}); end
        total++; if ({ifb.mem_rd_out, ifb.mem_addr_out, ifb.pixel_data_valid_out, ifb.pixel_data_out, ifb.busy_out, ifb.frame_done_out, ifb.credit_err_out} !== 31'd0) begin
            bad++; $display("FAIL reset_outs_b got=%h want=0", {ifb.mem_rd_out, ifb.mem_addr_out, ifb.pixel_data_valid_out, ifb.pixel_data_out, ifb.busy_out, ifb.frame_done_out, ifb.credit_err_out}); end
        rst_n = 1'b1;
        step(1);
        ld = 1'b1; step(1); ld = 1'b0; step(1);
        total++; if (ifa.credit_err_out !== 1'b0) begin bad++; $display("FAIL idle_ld_err got=%0d want=0", ifa.credit_err_out); end
        total++; if (ifa.busy_out !== 1'b0) begin bad++; $display("FAIL idle_ld_busy got=%0d want=0", ifa.busy_out); end
    endtask

    task automatic test_preload();
        clr_mon();
        total++; if (ifa.busy_out !== 1'b0) begin bad++; $display("FAIL t1_busy_c0 got=%0d want=0", ifa.busy_out); end
        pulse_start();
        total++; if (ifa.mem_rd_out !== 1'b1) begin bad++; $display("FAIL t1_rd_c1 got=%0d want=1", ifa.mem_rd_out); end
        total++; if (ifa.mem_addr_out !== 17'd0) begin bad++; $display("FAIL t1_addr_c1 got=%0d want=0", ifa.mem_addr_out); end
        total++; if (ifa.busy_out !== 1'b1) begin bad++; $display("FAIL t1_busy_c1 got=%0d want=1", ifa.busy_out); end
        total++; if ({ifa.pixel_data_valid_out, ifb.pixel_data_valid_out} !== 2'b00) begin bad++; $display("FAIL t1_vld_c1 got=%b want=00", {ifa.pixel_data_valid_out, ifb.pixel_data_valid_out}); end
        step(1);
        total++; if ({ifa.pixel_data_valid_out, ifb.pixel_data_valid_out} !== 2'b10) begin bad++; $display("FAIL t1_vld_c2 got=%b want=10", {ifa.pixel_data_valid_out, ifb.pixel_data_valid_out}); end
        step(1);
        total++; if (ifb.pixel_data_valid_out !== 1'b0) begin bad++; $display("FAIL t6_vld_b_c3 got=%0d want=0", ifb.pixel_data_valid_out); end
        step(1);
        total++; if (ifb.pixel_data_valid_out !== 1'b1) begin bad++; $display("FAIL t6_vld_b_c4 got=%0d want=1", ifb.pixel_data_valid_out); end
        total++; if (ifb.pixel_data_out !== 8'd0) begin bad++; $display("FAIL t6_pix_b_c4 got=%0d want=0", ifb.pixel_data_out); end
        step(1400);
        total++; if (rd_cnt[0] !== 1280) begin bad++; $display("FAIL t1_rd_cnt got=%0d want=1280", rd_cnt[0]); end
        total++; if (addr_err[0] !== 0) begin bad++; $display("FAIL t1_addr_err got=%0d want=0", addr_err[0]); end
        total++; if (bursts[0] !== 1) begin bad++; $display("FAIL t1_bursts got=%0d want=1", bursts[0]); end
        total++; if (pix_cnt[0] !== 1280) begin bad++; $display("FAIL t1_pix_cnt_a got=%0d want=1280", pix_cnt[0]); end
        total++; if (pix_cnt[1] !== 1280) begin bad++; $display("FAIL t1_pix_cnt_b got=%0d want=1280", pix_cnt[1]); end
        total++; if (pix_err[0] + pix_err[1] !== 0) begin bad++; $display("FAIL t1_pix_err got=%0d want=0", pix_err[0] + pix_err[1]); end
        total++; if (ifa.mem_rd_out !== 1'b0) begin bad++; $display("FAIL t1_rd_stall got=%0d want=0", ifa.mem_rd_out); end
        total++; if (ifa.busy_out !== 1'b1) begin bad++; $display("FAIL t1_busy_stall got=%0d want=1", ifa.busy_out); end
        total++; if (fd_cnt[0] !== 0) begin bad++; $display("FAIL t1_fd got=%0d want=0", fd_cnt[0]); end
    endtask

    task automatic test_one_line();
        ld = 1'b1; step(1); ld = 1'b0;
        step(400);
        total++; if (rd_cnt[0] !== 1600) begin bad++; $display("FAIL t2_rd_cnt got=%0d want=1600", rd_cnt[0]); end
        total++; if (bursts[0] !== 2) begin bad++; $display("FAIL t2_bursts got=%0d want=2", bursts[0]); end
        total++; if (addr_err[0] !== 0) begin bad++; $display("FAIL t2_addr_err got=%0d want=0", addr_err[0]); end
        total++; if (pix_cnt[1] !== 1600) begin bad++; $display("FAIL t2_pix_cnt_b got=%0d want=1600", pix_cnt[1]); end
        total++; if (pix_err[1] !== 0) begin bad++; $display("FAIL t2_pix_err_b got=%0d want=0", pix_err[1]); end
        total++; if (ifa.mem_rd_out !== 1'b0) begin bad++; $display("FAIL t2_rd_stall got=%0d want=0", ifa.mem_rd_out); end
        total++; if (ifa.credit_err_out !== 1'b0) begin bad++; $display("FAIL t2_err got=%0d want=0", ifa.credit_err_out); end
    endtask

    task automatic test_full_frame();
        int unsigned cyc = 1;
        int unsigned due = 0;
        do_reset();
        clr_mon();
        pulse_start();
        // line_done 50 cycles after each line end; a stray start at cycle 1000 must be ignored
        while ((fd_cnt[0] == 0 || fd_cnt[1] == 0) && cyc < 90000) begin
            ld    = (due != 0) && (cyc == due);
            start = (cyc == 1000);
            if (ifa.mem_rd_out && ((ifa.mem_addr_out % 17'd320) == 17'd319)) due = cyc + 50;
            step(1);
            cyc++;
        end
        ld = 1'b0;
        start = 1'b0;
        step(5);
        total++; if (rd_cnt[0] !== 76800) begin bad++; $display("FAIL t3_rd_cnt got=%0d want=76800", rd_cnt[0]); end
        total++; if (addr_err[0] !== 0) begin bad++; $display("FAIL t3_addr_err got=%0d want=0", addr_err[0]); end
        total++; if (bursts[0] !== 1) begin bad++; $display("FAIL t3_bursts got=%0d want=1", bursts[0]); end
        total++; if (pix_cnt[0] !== 76800) begin bad++; $display("FAIL t3_pix_cnt_a got=%0d want=76800", pix_cnt[0]); end
        total++; if (pix_err[0] !== 0) begin bad++; $display("FAIL t3_pix_err_a got=%0d want=0", pix_err[0]); end
        total++; if (pix_cnt[1] !== 76800) begin bad++; $display("FAIL t6_pix_cnt_b got=%0d want=76800", pix_cnt[1]); end
        total++; if (pix_err[1] !== 0) begin bad++; $display("FAIL t6_pix_err_b got=%0d want=0", pix_err[1]); end
        total++; if (fd_cnt[0] !== 1) begin bad++; $display("FAIL t3_fd_cnt_a got=%0d want=1", fd_cnt[0]); end
        total++; if (fd_cnt[1] !== 1) begin bad++; $display("FAIL t6_fd_cnt_b got=%0d want=1", fd_cnt[1]); end
        total++; if (fd_align_err[0] + fd_align_err[1] !== 0) begin bad++; $display("FAIL t3_fd_align got=%0d want=0", fd_align_err[0] + fd_align_err[1]); end
        total++; if ({ifa.busy_out, ifb.busy_out} !== 2'b00) begin bad++; $display("FAIL t3_busy_end got=%b want=00", {ifa.busy_out, ifb.busy_out}); end
        total++; if (ifa.credit_err_out !== 1'b0) begin bad++; $display("FAIL t3_err got=%0d want=0", ifa.credit_err_out); end
    endtask

    task automatic test_coincident();
        do_reset();
        clr_mon();
        pulse_start();
        for (int k = 0; k < 2000 && !(ifa.mem_rd_out && ifa.mem_addr_out == 17'd1279); k++) step(1);
        ld = 1'b1; step(1); ld = 1'b0;
        total++; if (ifa.mem_rd_out !== 1'b1) begin bad++; $display("FAIL t4_rd_next got=%0d want=1", ifa.mem_rd_out); end
        total++; if (ifa.mem_addr_out !== 17'd1280) begin bad++; $display("FAIL t4_addr_next got=%0d want=1280", ifa.mem_addr_out); end
        step(400);
        total++; if (rd_cnt[0] !== 1600) begin bad++; $display("FAIL t4_rd_cnt got=%0d want=1600", rd_cnt[0]); end
        total++; if (bursts[0] !== 1) begin bad++; $display("FAIL t4_bursts got=%0d want=1", bursts[0]); end
        total++; if (ifa.mem_rd_out !== 1'b0) begin bad++; $display("FAIL t4_rd_stall got=%0d want=0", ifa.mem_rd_out); end
        total++; if (ifa.credit_err_out !== 1'b0) begin bad++; $display("FAIL t4_err got=%0d want=0", ifa.credit_err_out); end
    endtask

    task automatic test_credit_err();
        do_reset();
        clr_mon();
        pulse_start();
        step(10);
        ld = 1'b1; step(1); ld = 1'b0;
        total++; if (ifa.credit_err_out !== 1'b1) begin bad++; $display("FAIL t5_err_set got=%0d want=1", ifa.credit_err_out); end
        step(20);
        total++; if (ifa.credit_err_out !== 1'b1) begin bad++; $display("FAIL t5_err_sticky got=%0d want=1", ifa.credit_err_out); end
        total++; if (ifa.mem_rd_out !== 1'b1) begin bad++; $display("FAIL t5_rd_midline got=%0d want=1", ifa.mem_rd_out); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({ifa.mem_rd_out, ifa.mem_addr_out, ifa.pixel_data_valid_out, ifa.pixel_data_out, ifa.busy_out, ifa.frame_done_out, ifa.credit_err_out} !== 31'd0) begin
            bad++; $display("FAIL t5_async_rst_a got=%h want=0", {ifa.mem_rd_out, ifa.mem_addr_out, ifa.pixel_data_valid_out, ifa.pixel_data_out, ifa.busy_out, ifa.frame_done_out, ifa.credit_err_out}); end
        total++; if ({ifb.mem_rd_out, ifb.pixel_data_valid_out, ifb.busy_out} !== 3'b000) begin bad++; $display("FAIL t5_async_rst_b got=%b want=000", {ifb.mem_rd_out, ifb.pixel_data_valid_out, ifb.busy_out}); end
        step(1);
        rst_n = 1'b1;
        step(1);
        clr_mon();
        pulse_start();
        total++; if (ifa.mem_addr_out !== 17'd0) begin bad++; $display("FAIL t5_restart_addr got=%0d want=0", ifa.mem_addr_out); end
        total++; if (ifa.mem_rd_out !== 1'b1) begin bad++; $display("FAIL t5_restart_rd got=%0d want=1", ifa.mem_rd_out); end
        step(30);
        total++; if (addr_err[0] !== 0) begin bad++; $display("FAIL t5_restart_addr_err got=%0d want=0", addr_err[0]); end
        total++; if (pix_err[1] !== 0) begin bad++; $display("FAIL t5_restart_pix_err_b got=%0d want=0", pix_err[1]); end
        total++; if (pix_cnt[1] !== 27) begin bad++; $display("FAIL t5_restart_pix_cnt_b got=%0d want=27", pix_cnt[1]); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_one_line();
        test_full_frame();
        test_coincident();
        test_credit_err();
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
